adder_tree_ctrl: RTL

Sequencer for the 9-input pipelined adder tree that sums PE-array products plus bias into one OFM pixel.
- Accepts one product vector per pixel from the PE array over a valid/ready handshake.
- Drives the tree's global `ready_adder` advance enable and tracks pipeline occupancy with a valid shift register.
- Presents each finished pixel downstream with an OFM address, applying backpressure end-to-end.
- Sits between the PE-array control and the OFM write buffer; runs one pass of `cfg_num_pix` pixels per start.

---
 rtl/adder_tree_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/adder_tree_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adder_tree_ctrl
//  Purpose  : Sequencer for the 9-input pipelined adder tree. Accepts one
//             product vector per pixel, advances the tree with a global
//             enable, tracks occupancy with a valid pipe and hands finished
//             pixels downstream with their OFM address.
//  Options  : ADDER_CTRL_PERF_EN adds saturating stall/bubble counters.
//  Revision : 1.0  initial release
// ============================================================================
module adder_tree_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_num_pix,
  input  logic [CNT_W-1:0] cfg_base_addr,
  input  logic             pe_valid,
  output logic             pe_ready,
  output logic             ready_adder,
  output logic             ofm_valid,
  input  logic             ofm_ready,
  output logic [CNT_W-1:0] ofm_addr,
  output logic             busy,
  output logic             done
`ifdef ADDER_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] vld_shift;
  logic [LATENCY-1:0] vld_nxt;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   retired;
  logic [CNT_W-1:0]   issued_nxt;
  logic [CNT_W-1:0]   retired_nxt;
  logic [CNT_W-1:0]   num_pix;
  logic [CNT_W-1:0]   base_addr;
  logic               active;
  logic               adv;
  logic               cap;
  logic               ret;
  logic               start_acc;

  // Handshake and advance qualifiers; a stalled output freezes the whole tree.
  assign start_acc   = start && (state == S_IDLE);
  assign active      = (state == S_RUN) || (state == S_DRAIN);
  assign adv         = active && (!vld[LATENCY-1] || ofm_ready);
  assign pe_ready    = adv && (state == S_RUN);
  assign cap         = pe_valid && pe_ready;
  assign ofm_valid   = vld[LATENCY-1];
  assign ret         = ofm_valid && ofm_ready;
  assign ready_adder = adv;
  assign busy        = active;
  assign done        = (state == S_DONE);
  assign ofm_addr    = base_addr + retired;

  assign issued_nxt  = issued  + {{(CNT_W-1){1'b0}}, cap};
  assign retired_nxt = retired + {{(CNT_W-1){1'b0}}, ret};

  // Valid pipe shifted by one stage per advance; a single-stage tree just loads.
  if (LATENCY > 1) begin : g_pipe_multi
    assign vld_shift = {vld[LATENCY-2:0], cap};
  end else begin : g_pipe_single
    assign vld_shift = cap;
  end

  // Pipe only moves on advance, so a stall holds every stage in place.
  always_comb begin
    vld_nxt = vld;
    if (adv) begin
      vld_nxt = vld_shift;
    end
  end

  // Next-state: transitions look at the post-handshake counts so that no extra
  // vector is captured after the last one and done follows the final retire.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_num_pix == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issued_nxt == num_pix) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (retired_nxt == num_pix) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pipe occupancy, counters and configuration captured on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vld       <= '0;
      issued    <= '0;
      retired   <= '0;
      num_pix   <= '0;
      base_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        vld       <= '0;
        issued    <= '0;
        retired   <= '0;
        num_pix   <= cfg_num_pix;
        base_addr <= cfg_base_addr;
      end else begin
        vld     <= vld_nxt;
        issued  <= issued_nxt;
        retired <= retired_nxt;
      end
    end
  end

`ifdef ADDER_CTRL_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = active && !adv;
  assign bubble_inc = (state == S_RUN) && adv && !pe_valid;

  // Saturating performance counters, cleared when a pass begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (start_acc) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (stall_inc && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
      if (bubble_inc && (perf_bubble_cnt != '1)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
      end
    end
  end
`else
  // Without performance monitoring there is no extra state to maintain.
`endif

endmodule
`default_nettype wire
